// File: rtl/sound_pkg.sv
// Shared types and constants for the sound store playback path.
package sound_pkg;

    localparam int DEPTH_WORDS    = 500;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_PREFILL = 2'd0,
        ST_READY   = 2'd1,
        ST_FETCH   = 2'd2
    } play_state_e;

endpackage

// File: rtl/sound_fill_ctr.sv
// Buffer fill tracker: assembles writer byte strobes into whole words and
// keeps the count of buffered words, flagging words that arrive into a full buffer.
module sound_fill_ctr
    import sound_pkg::*;
#(
    parameter int DEPTH = DEPTH_WORDS,
    parameter int LW    = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          byte_wr,
    input  logic          word_sub,
    input  logic          clear_flags,
    output logic [LW-1:0] level,
    output logic          overrun
);

    localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]    phase_q, phase_d;
    logic [LW-1:0] level_q, level_d;
    logic          overrun_q, overrun_d;
    logic          word_add_s;
    logic          full_add_s;

    assign word_add_s = byte_wr && (phase_q == LAST_PHASE);

    // Next byte phase, word count and sticky overrun flag.
    always_comb begin
        phase_d    = phase_q;
        level_d    = level_q;
        full_add_s = 1'b0;
        if (byte_wr) begin
            phase_d = phase_q + 2'd1;
        end else begin
            phase_d = phase_q;
        end
        // A word completing into a full buffer is lost; the count saturates.
        if (word_add_s && !word_sub) begin
            if (level_q == LW'(DEPTH)) begin
                full_add_s = 1'b1;
            end else begin
                level_d = level_q + LW'(1);
            end
        end else if (word_sub && !word_add_s && (level_q != '0)) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
        if (clear_flags) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q | full_add_s;
        end
    end

    // Fill-tracking state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q   <= 2'd0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign level   = level_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sound_play_sched.sv
// Playback scheduler: prefills the sound buffer, then fetches one word per codec
// frame from the RAM read port and presents it as left/right samples.
module sound_play_sched
    import sound_pkg::*;
#(
    parameter int DEPTH   = DEPTH_WORDS,
    parameter int PREFILL = 250,
    parameter int RD_LAT  = 2,
    parameter int AW      = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          byte_wr,
    input  logic          frame,
    input  logic          clear_flags,
    output logic [AW-1:0] rdaddress,
    input  logic [31:0]   q,
    output logic [15:0]   left,
    output logic [15:0]   right,
    output logic          sample_valid,
    output logic [9:0]    level,
    output logic          playing,
    output logic          underrun,
    output logic          overrun
);

    localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    play_state_e   state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   left_q, left_d;
    logic [15:0]   right_q, right_d;
    logic          valid_q, valid_d;
    logic          playing_q;
    logic          underrun_q, underrun_d;
    logic          under_set_s;
    logic          word_sub_s;
    logic [9:0]    level_s;

    sound_fill_ctr #(
        .DEPTH (DEPTH),
        .LW    (10)
    ) u_fill (
        .clock       (clock),
        .reset       (reset),
        .byte_wr     (byte_wr),
        .word_sub    (word_sub_s),
        .clear_flags (clear_flags),
        .level       (level_s),
        .overrun     (overrun)
    );

    // Playback FSM: next state, fetch timing, sample capture and pointer advance.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        under_set_s = 1'b0;
        word_sub_s  = 1'b0;
        case (state_q)
            ST_PREFILL: begin
                if (enable && (level_s >= 10'(PREFILL))) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_PREFILL;
                end
            end
            ST_READY: begin
                if (!enable) begin
                    state_d = ST_PREFILL;
                end else if (frame && (level_s != '0)) begin
                    wait_d  = CW'(RD_LAT);
                    state_d = ST_FETCH;
                end else if (frame) begin
                    // Starved frame: emit silence and rebuild the prefill margin.
                    under_set_s = 1'b1;
                    left_d      = 16'h0000;
                    right_d     = 16'h0000;
                    valid_d     = 1'b1;
                    state_d     = ST_PREFILL;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_FETCH: begin
                // The word is consumed on the issue cycle even if the fetch is later abandoned.
                word_sub_s = (wait_q == CW'(RD_LAT));
                if (!enable) begin
                    state_d = ST_PREFILL;
                end else if (wait_q == '0) begin
                    left_d  = q[15:0];
                    right_d = q[31:16];
                    valid_d = 1'b1;
                    addr_d  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    state_d = ST_READY;
                end else begin
                    wait_d  = wait_q - CW'(1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_PREFILL;
            end
        endcase
        if (clear_flags) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q | under_set_s;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_PREFILL;
            wait_q     <= '0;
            addr_q     <= '0;
            left_q     <= 16'h0000;
            right_q    <= 16'h0000;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            playing_q  <= (state_d != ST_PREFILL);
            underrun_q <= underrun_d;
        end
    end

    assign rdaddress    = addr_q;
    assign left         = left_q;
    assign right        = right_q;
    assign sample_valid = valid_q;
    assign level        = level_s;
    assign playing      = playing_q;
    assign underrun     = underrun_q;

endmodule
